// File: rtl/ucode_loader_if.sv
// Stream-in / control-memory-write bus of the microcode loader.
// slave = loader side, master = producer/harness side.
interface ucode_loader_if #(
    parameter int P_LOG_MEMSIZE = 4,
    parameter int P_WORD_W      = 11
);
    logic                     in_valid;
    logic [P_WORD_W-1:0]      in_data;
    logic                     in_last;
    logic                     in_ready;
    logic                     mem_we;
    logic [P_LOG_MEMSIZE-1:0] mem_addr;
    logic [P_WORD_W-1:0]      mem_wdata;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ucode_loader.sv
// Streams microcode words into the sequencer control memory from address 0 and
// holds the core in reset until loaded. Optional UCODE_LOADER_ZERO_FILL_EN zero-fills the tail.
module ucode_loader #(
    parameter int P_LOG_MEMSIZE = 4,
    parameter int P_WORD_W      = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    ucode_loader_if.slave  bus,
    output logic           core_rst,
    output logic           done,
    output logic           err_overflow
);

    localparam int                   DEPTH   = 2 ** P_LOG_MEMSIZE;
    localparam logic [P_LOG_MEMSIZE:0] CNT_TOP = (P_LOG_MEMSIZE+1)'(DEPTH - 1);
    localparam logic [P_LOG_MEMSIZE:0] CNT_ONE = (P_LOG_MEMSIZE+1)'(1);

`ifdef UCODE_LOADER_ZERO_FILL_EN
    typedef enum logic [2:0] {IDLE, LOAD, FILL, RELEASE, RUN, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, ERR} state_t;
`endif

    state_t                   state, state_nxt;
    logic [P_LOG_MEMSIZE:0]   cnt, cnt_nxt;
    logic                     in_ready_p0, in_ready_nxt;
    logic                     mem_we_p0, mem_we_nxt;
    logic [P_LOG_MEMSIZE-1:0] mem_addr_p0, mem_addr_nxt;
    logic [P_WORD_W-1:0]      mem_wdata_p0, mem_wdata_nxt;
    logic                     core_rst_p0, core_rst_nxt;
    logic                     done_p0, done_nxt;
    logic                     err_p0, err_nxt;
    logic                     accept;

    // True when the counter points at the last control-memory address.
    function automatic logic at_top(input logic [P_LOG_MEMSIZE:0] c);
        return c == CNT_TOP;
    endfunction

    function automatic logic [P_LOG_MEMSIZE-1:0] addr_of(input logic [P_LOG_MEMSIZE:0] c);
        return c[P_LOG_MEMSIZE-1:0];
    endfunction

    assign accept = bus.in_valid & in_ready_p0;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        in_ready_nxt  = in_ready_p0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr_p0;
        mem_wdata_nxt = mem_wdata_p0;
        core_rst_nxt  = core_rst_p0;
        done_nxt      = done_p0;
        err_nxt       = err_p0;

        case (state)
            IDLE: begin
                core_rst_nxt = 1'b1;
                if (start) begin
                    state_nxt    = LOAD;
                    cnt_nxt      = '0;
                    in_ready_nxt = 1'b1;
                end
            end

            LOAD: begin
                if (accept) begin
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = addr_of(cnt);
                    mem_wdata_nxt = bus.in_data;
                    cnt_nxt       = cnt + CNT_ONE;
                    if (bus.in_last) begin
                        in_ready_nxt = 1'b0;
`ifdef UCODE_LOADER_ZERO_FILL_EN
                        state_nxt    = at_top(cnt) ? RELEASE : FILL;
`else
                        state_nxt    = RELEASE;
`endif
                    end else if (at_top(cnt)) begin
                        // Memory full and the program has not ended: refuse further words.
                        in_ready_nxt = 1'b0;
                        err_nxt      = 1'b1;
                        state_nxt    = ERR;
                    end
                end
            end

`ifdef UCODE_LOADER_ZERO_FILL_EN
            FILL: begin
                mem_we_nxt    = 1'b1;
                mem_addr_nxt  = addr_of(cnt);
                mem_wdata_nxt = '0;
                cnt_nxt       = cnt + CNT_ONE;
                if (at_top(cnt)) begin
                    state_nxt = RELEASE;
                end
            end
`endif

            // RELEASE is the cycle carrying the final memory write.
            RELEASE: begin
                state_nxt    = RUN;
                core_rst_nxt = 1'b0;
                done_nxt     = 1'b1;
            end

            RUN: begin
                if (start) begin
                    state_nxt    = LOAD;
                    cnt_nxt      = '0;
                    in_ready_nxt = 1'b1;
                    core_rst_nxt = 1'b1;
                    done_nxt     = 1'b0;
                end
            end

            ERR: begin
                if (start) begin
                    state_nxt    = LOAD;
                    cnt_nxt      = '0;
                    in_ready_nxt = 1'b1;
                    err_nxt      = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p0: all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            in_ready_p0  <= 1'b0;
            mem_we_p0    <= 1'b0;
            mem_addr_p0  <= '0;
            mem_wdata_p0 <= '0;
            core_rst_p0  <= 1'b1;
            done_p0      <= 1'b0;
            err_p0       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            in_ready_p0  <= in_ready_nxt;
            mem_we_p0    <= mem_we_nxt;
            mem_addr_p0  <= mem_addr_nxt;
            mem_wdata_p0 <= mem_wdata_nxt;
            core_rst_p0  <= core_rst_nxt;
            done_p0      <= done_nxt;
            err_p0       <= err_nxt;
        end
    end

    assign bus.in_ready  = in_ready_p0;
    assign bus.mem_we    = mem_we_p0;
    assign bus.mem_addr  = mem_addr_p0;
    assign bus.mem_wdata = mem_wdata_p0;
    assign core_rst      = core_rst_p0;
    assign done          = done_p0;
    assign err_overflow  = err_p0;

endmodule

// File: tb/tb_ucode_loader.sv
// Scoreboard bench for ucode_loader: expected memory writes are queued on each accepted
// word (plus zero-fill writes when UCODE_LOADER_ZERO_FILL_EN is defined) and popped per mem_we.
module tb_ucode_loader;

    localparam int LOGD = 4;
    localparam int WW   = 11;
    localparam int D    = 16;

    typedef struct packed {
        logic [LOGD-1:0] a;
        logic [WW-1:0]   d;
    } sb_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic core_rst, done, err_overflow;

    ucode_loader_if #(.P_LOG_MEMSIZE(LOGD), .P_WORD_W(WW)) bus ();

    ucode_loader #(.P_LOG_MEMSIZE(LOGD), .P_WORD_W(WW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .core_rst     (core_rst),
        .done         (done),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int      checks   = 0;
    int      failures = 0;
    int      exp_addr = 0;
    sb_ent_t sb[$];
    sb_ent_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexp_we", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.a));
                chk("wr_data", 32'(bus.mem_wdata), 32'(mon_e.d));
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 0;
    endtask

    task automatic send(input logic [WW-1:0] d, input logic last);
        logic ok;
        logic accepted;
        accepted = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            if (ok === 1'b1) begin
                sb.push_back('{a: LOGD'(exp_addr), d: d});
                exp_addr++;
                accepted = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!accepted) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    // Called right after the last word is accepted.
    task automatic finish_load(input string tag);
`ifdef UCODE_LOADER_ZERO_FILL_EN
        for (int a = exp_addr; a < D; a++) sb.push_back('{a: LOGD'(a), d: '0});
`endif
        @(negedge clk);
        chk({tag, "_rel_core_rst"}, 32'(core_rst), 32'd1);
        chk({tag, "_rel_done"}, 32'(done), 32'd0);
        chk({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd0);
`ifdef UCODE_LOADER_ZERO_FILL_EN
        wait_done();
`else
        @(negedge clk);
`endif
        chk({tag, "_run_core_rst"}, 32'(core_rst), 32'd0);
        chk({tag, "_run_done"}, 32'(done), 32'd1);
        chk({tag, "_run_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err_overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // Reset state, held until start
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst");
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        rst = 1'b0;
        idle(3);
        @(negedge clk);
        check_idle_outputs("idle_hold");
        @(posedge clk); #1;

        // Basic back-to-back load
        do_start();
        @(negedge clk);
        chk("load_ready", 32'(bus.in_ready), 32'd1);
        chk("load_core_rst", 32'(core_rst), 32'd1);
        @(posedge clk); #1;
        send(11'h101, 1'b0);
        send(11'h202, 1'b0);
        send(11'h303, 1'b1);
        finish_load("basic");

        // Gapped stream: valid 1,0,0,1,1(last)
        do_start();
        send(11'h011, 1'b0);
        idle(2);
        send(11'h022, 1'b0);
        send(11'h033, 1'b1);
        finish_load("gap");

        // Overflow: 16 words, none marked last
        do_start();
        for (int i = 0; i < D; i++) send(WW'(12'h040 + i), 1'b0);
        @(negedge clk);
        chk("ovf_err", 32'(err_overflow), 32'd1);
        chk("ovf_ready", 32'(bus.in_ready), 32'd0);
        chk("ovf_core_rst", 32'(core_rst), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        idle(3);
        @(negedge clk);
        chk("ovf_err_hold", 32'(err_overflow), 32'd1);
        chk("ovf_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        do_start();
        @(negedge clk);
        chk("ovf_clear_err", 32'(err_overflow), 32'd0);
        chk("ovf_clear_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        send(11'h555, 1'b1);
        finish_load("ovf_restart");

        // Full-depth program with last on the final word: normal completion
        do_start();
        for (int i = 0; i < D; i++) send(WW'(12'h600 + i), (i == D - 1));
        finish_load("full");
        chk("full_no_err", 32'(err_overflow), 32'd0);

        // Reprogram from RUN
        do_start();
        @(negedge clk);
        chk("rep_core_rst", 32'(core_rst), 32'd1);
        chk("rep_done", 32'(done), 32'd0);
        chk("rep_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        send(11'h7A1, 1'b0);
        send(11'h7B2, 1'b1);
        finish_load("rep");

        // One-word program
        do_start();
        send(11'h7FF, 1'b1);
        finish_load("one");

        // Asynchronous reset mid-load while a write is on the bus
        do_start();
        send(11'h0AA, 1'b0);
        send(11'h0BB, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("arst");
        #1 rst = 1'b0;
        idle(3);
        @(negedge clk);
        check_idle_outputs("arst_hold");
        chk("arst_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        do_start();
        send(11'h0CC, 1'b0);
        send(11'h0DD, 1'b1);
        finish_load("arst_restart");

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ucode_loader.md
Name: ucode_loader

Overview:
- Upstream stage of the control sequencer.
- Accepts a stream of microcode control words over a valid/ready handshake and writes them into the sequencer's control memory, starting at address 0.
- Holds the datapath/sequencer in reset while loading, then releases it to run.
- Lets the test harness or host reprogram the pseudo-CPU without re-elaborating the memory image.

Parameters:
P_LOG_MEMSIZE, 4, log2 of control-memory depth; depth D = 2**P_LOG_MEMSIZE.
P_WORD_W, 11, control-word width: datapath ctrl bits (5) + condition ctrl bits (2) + next-address field (4).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle request to begin a load; sampled every cycle.
in_valid  in  1  word available on in_data.
in_data  in  P_WORD_W  control word.
in_last  in  1  qualifies in_data as the final word of the program.
in_ready  out  1  loader can accept a word this cycle.
mem_we  out  1  control-memory write strobe.
mem_addr  out  P_LOG_MEMSIZE  write address.
mem_wdata  out  P_WORD_W  write data.
core_rst  out  1  reset to sequencer/datapath, active-high.
done  out  1  program loaded, core running.
err_overflow  out  1  memory filled without in_last.

Behaviour:
- Reset values: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, err_overflow=0, word counter cnt=0. All outputs are registered.
- States: IDLE, LOAD, FILL (only with the optional feature), RELEASE, RUN, ERR.
- IDLE:
  - core_rst=1.
  - start=1 -> LOAD next cycle with cnt=0, in_ready=1.
- LOAD:
  - in_ready=1. A transfer occurs when in_valid&in_ready at a rising edge.
  - Transfer at edge t: mem_we=1, mem_addr=cnt, mem_wdata=in_data during cycle t+1 (1-cycle latency); cnt increments.
  - mem_we=0 on any cycle following an edge with no transfer.
  - start is ignored in LOAD.
- Transfer with in_last=1:
  - in_ready=0 from t+1.
  - Next state is RELEASE, or FILL when the optional feature is enabled.
- RELEASE: lasts one cycle (the cycle carrying the final write), then RUN.
- RUN:
  - core_rst=0 and done=1, both asserted together.
  - Without the fill feature, this is the second cycle after the accept edge of the last word.
- Transfer at cnt=D-1 with in_last=0:
  - The word is written to address D-1.
  - Next state is ERR: err_overflow=1, in_ready=0, core_rst stays 1, done=0.
- Transfer at cnt=D-1 with in_last=1: normal completion, no error.
- ERR: start -> LOAD with cnt=0; err_overflow clears on the same edge.
- start in RUN: next cycle core_rst=1, done=0, state LOAD, cnt=0. A restart always overwrites from address 0.
- start in RELEASE or FILL: ignored.
- cnt is P_LOG_MEMSIZE+1 bits wide. mem_addr never wraps within one load.
- rst asserted at any time: immediate return to reset values. A write in progress is abandoned, and partial memory contents are not cleared.
- A one-word program (first word has in_last=1) is legal.

Optional Feature:
UCODE_LOADER_ZERO_FILL_EN
- Defined:
  - After the last word, the FILL state writes the all-zero word to every remaining address, cnt..D-1, one per cycle (mem_we=1 each cycle).
  - RUN is entered the cycle after the write to D-1.
  - If the last word landed at D-1, FILL is skipped.
  - This guarantees that unloaded addresses never hold stale microcode.
- Undefined: no FILL state; remaining addresses are left untouched.

Test Plan:
- Reset: rst pulse mid-cycle -> immediately core_rst=1, in_ready=0, mem_we=0, done=0, err_overflow=0; all held until start.
- Basic load (D=16): start, then back-to-back 0x101, 0x202, 0x303 (last) -> mem_we on 3 consecutive cycles at addr 0/1/2 with matching data. Then core_rst=0 and done=1 two cycles after the last accept; in_ready=0 from then on.
- Gapped stream: in_valid pattern 1,0,0,1,1(last) -> writes to addr 0,1,2 only, no mem_we on idle cycles, addresses contiguous.
- Overflow: 16 words, none with last -> 16 writes at addr 0..15, then err_overflow=1, core_rst=1, in_ready=0. Then start -> err_overflow=0 and the next word is written to addr 0.
- Reprogram: start while in RUN -> core_rst=1 and done=0 the next cycle; a new 2-word load writes addr 0,1; the core is released again.
- Zero fill (macro defined): 3-word load -> words at 0..2, zeros written at 3..15 over 13 consecutive cycles, core_rst=0 the cycle after the write to addr 15. rst asserted mid-LOAD in the same bench -> reset values, and the following start restarts at addr 0.
